// File: rtl/game_pkg.sv
// Shared game constants for the safe-zone logic: default screen/block geometry,
// derived block counts, the checker state encoding and a counter-width helper.
package game_pkg;

    localparam int DEF_SCREEN_WIDTH  = 800;
    localparam int DEF_SCREEN_HEIGHT = 600;
    localparam int DEF_BLOCK_SIZE    = 10;

    localparam int DEF_BLOCKS_X      = DEF_SCREEN_WIDTH / DEF_BLOCK_SIZE;
    localparam int DEF_BLOCKS_Y      = DEF_SCREEN_HEIGHT / DEF_BLOCK_SIZE;
    localparam int DEF_BLOCKS_TOTAL  = DEF_BLOCKS_X * DEF_BLOCKS_Y;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_MAP = 3'd2,
        ST_QUERY    = 3'd3,
        ST_SAMPLE   = 3'd4,
        ST_DONE     = 3'd5
    } chk_state_t;

    // Width able to hold every block count 0..total blocks on the screen.
    function automatic int unsafe_cnt_width(input int sw, input int sh, input int bs);
        return $clog2((sw / bs) * (sh / bs) + 1);
    endfunction

endpackage

// File: rtl/zone_span_calc.sv
// One-axis span of a box over the block grid: first and last block index
// covered by [pos, pos+len-1], with the far edge clipped to LIMIT-1.
// A zero length (or a start beyond the screen) reports an empty span.
module zone_span_calc #(
    parameter int LIMIT = 800,
    parameter int BS    = 10,
    parameter int W     = $clog2(LIMIT)
) (
    input  logic [W-1:0] i_pos,
    input  logic [W-1:0] i_len,
    output logic [W-1:0] o_first,
    output logic [W-1:0] o_last,
    output logic         o_empty
);

    // End coordinate kept one bit wider so pos+len cannot wrap.
    logic [W:0] w_end;
    logic [W:0] w_edge;

    assign w_end   = {1'b0, i_pos} + {1'b0, i_len} - (W+1)'(1);
    assign w_edge  = (w_end > (W+1)'(LIMIT - 1)) ? (W+1)'(LIMIT - 1) : w_end;
    assign o_first = i_pos / W'(BS);
    assign o_last  = W'(w_edge / (W+1)'(BS));
    // Off-screen start would give first > last; treat it as nothing to scan.
    assign o_empty = (i_len == '0) || ({1'b0, i_pos} >= (W+1)'(LIMIT));

endmodule

// File: rtl/safe_zone_checker.sv
// Safe-zone checker: walks every map block under a player box, one point
// query per step, and reports whether all covered blocks are safe.
// Optional feature macro: SAFE_ZONE_UNSAFE_COUNT_EN (full scan + unsafe block count).
module safe_zone_checker
    import game_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int BLOCK_SIZE    = DEF_BLOCK_SIZE,
    parameter int QUERY_LAT     = 0,
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
    localparam int CW = unsafe_cnt_width(SCREEN_WIDTH, SCREEN_HEIGHT, BLOCK_SIZE),
`endif
    localparam int XW = $clog2(SCREEN_WIDTH),
    localparam int YW = $clog2(SCREEN_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [XW-1:0] i_px,
    input  logic [YW-1:0] i_py,
    input  logic [XW-1:0] i_pw,
    input  logic [YW-1:0] i_ph,
    input  logic          i_map_rdy,
    output logic [XW-1:0] o_qx,
    output logic [YW-1:0] o_qy,
    output logic          o_qvalid,
    input  logic          i_is_safe,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_safe
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
    ,
    output logic [CW-1:0] o_unsafe_cnt
`endif
);

    chk_state_t    r_state;
    chk_state_t    w_state_next;

    logic [XW-1:0] r_px, r_pw;
    logic [YW-1:0] r_py, r_ph;
    logic [XW-1:0] r_bx0, r_bx1, r_cx;
    logic [YW-1:0] r_by0, r_by1, r_cy;
    logic          r_all_safe;
    logic          r_safe;

    logic [XW-1:0] w_bx0, w_bx1, w_qx;
    logic [YW-1:0] w_by0, w_by1, w_qy;
    logic          w_x_empty, w_y_empty;
    logic          w_last;
    logic          w_sample_stage;
    logic          w_sample_unsafe;
    logic          w_result_safe;
    logic          w_early_exit;

`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_unsafe_cnt;
    logic [CW-1:0] w_cnt_next;
`endif

    zone_span_calc #(
        .LIMIT (SCREEN_WIDTH),
        .BS    (BLOCK_SIZE),
        .W     (XW)
    ) u_span_x (
        .i_pos   (r_px),
        .i_len   (r_pw),
        .o_first (w_bx0),
        .o_last  (w_bx1),
        .o_empty (w_x_empty)
    );

    zone_span_calc #(
        .LIMIT (SCREEN_HEIGHT),
        .BS    (BLOCK_SIZE),
        .W     (YW)
    ) u_span_y (
        .i_pos   (r_py),
        .i_len   (r_ph),
        .o_first (w_by0),
        .o_last  (w_by1),
        .o_empty (w_y_empty)
    );

    // The answer is taken in QUERY for a combinational map, in SAMPLE for a registered one.
    assign w_sample_stage  = (QUERY_LAT == 0) ? (r_state == ST_QUERY) : (r_state == ST_SAMPLE);
    assign w_sample_unsafe = w_sample_stage & i_map_rdy & ~i_is_safe;
    assign w_result_safe   = r_all_safe & ~w_sample_unsafe;
    assign w_last          = (r_cx == r_bx1) && (r_cy == r_by1);
    assign w_qx            = r_cx * XW'(BLOCK_SIZE);
    assign w_qy            = r_cy * YW'(BLOCK_SIZE);
    assign o_safe          = r_safe;

`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
    assign w_early_exit = 1'b0;
    assign w_cnt_next   = (w_sample_unsafe && (r_cnt != '1)) ? r_cnt + CW'(1) : r_cnt;
    assign o_unsafe_cnt = r_unsafe_cnt;
`else
    assign w_early_exit = w_sample_unsafe;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; losing map ready mid-scan always wins over the sample.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (w_x_empty || w_y_empty) w_state_next = ST_DONE;
                else if (i_map_rdy)         w_state_next = ST_QUERY;
                else                        w_state_next = ST_WAIT_MAP;
            end
            ST_WAIT_MAP: begin
                if (i_map_rdy) w_state_next = ST_QUERY;
            end
            ST_QUERY: begin
                if (!i_map_rdy)                  w_state_next = ST_WAIT_MAP;
                else if (QUERY_LAT != 0)         w_state_next = ST_SAMPLE;
                else if (w_last || w_early_exit) w_state_next = ST_DONE;
            end
            ST_SAMPLE: begin
                if (!i_map_rdy)                  w_state_next = ST_WAIT_MAP;
                else if (w_last || w_early_exit) w_state_next = ST_DONE;
                else                             w_state_next = ST_QUERY;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; the query address is held through SAMPLE.
    always_comb begin
        o_qvalid = 1'b0;
        o_qx     = '0;
        o_qy     = '0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        case (r_state)
            ST_SETUP, ST_WAIT_MAP: begin
                o_busy = 1'b1;
            end
            ST_QUERY: begin
                o_busy   = 1'b1;
                o_qvalid = 1'b1;
                o_qx     = w_qx;
                o_qy     = w_qy;
            end
            ST_SAMPLE: begin
                o_busy = 1'b1;
                o_qx   = w_qx;
                o_qy   = w_qy;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // Box latch, span registers, scan cursor and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_px       <= '0;
            r_py       <= '0;
            r_pw       <= '0;
            r_ph       <= '0;
            r_bx0      <= '0;
            r_bx1      <= '0;
            r_by0      <= '0;
            r_by1      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_all_safe <= 1'b1;
            r_safe     <= 1'b0;
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
            r_cnt        <= '0;
            r_unsafe_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_px       <= i_px;
                        r_py       <= i_py;
                        r_pw       <= i_pw;
                        r_ph       <= i_ph;
                        r_all_safe <= 1'b1;
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    r_bx0 <= w_bx0;
                    r_bx1 <= w_bx1;
                    r_by0 <= w_by0;
                    r_by1 <= w_by1;
                    r_cx  <= w_bx0;
                    r_cy  <= w_by0;
                end
                ST_QUERY, ST_SAMPLE: begin
                    if (!i_map_rdy) begin
                        // Map is regenerating: partial results are meaningless, rescan from the start.
                        r_cx       <= r_bx0;
                        r_cy       <= r_by0;
                        r_all_safe <= 1'b1;
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
                        r_cnt      <= '0;
`endif
                    end else if (w_sample_stage) begin
                        r_all_safe <= w_result_safe;
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
                        r_cnt      <= w_cnt_next;
`endif
                        if (!w_last) begin
                            if (r_cx == r_bx1) begin
                                r_cx <= r_bx0;
                                r_cy <= r_cy + YW'(1);
                            end else begin
                                r_cx <= r_cx + XW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_cx <= r_cx;
                end
            endcase

            // Published results change only as DONE is entered, so they line up with o_done.
            if (w_state_next == ST_DONE) begin
                r_safe <= w_result_safe;
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
                r_unsafe_cnt <= w_cnt_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_safe_zone_checker.sv
// Scoreboard bench for safe_zone_checker: one instance with a combinational
// map responder, one with a registered responder. Expected queries and
// results are queued at stimulus time and popped as the DUTs produce them.
`timescale 1ns/1ps
module tb_safe_zone_checker;

    localparam int XW = $clog2(800);
    localparam int YW = $clog2(600);

    logic          clk = 1'b0;
    logic          rst;
    logic          map_rdy;
    logic          start0, start1;
    logic [XW-1:0] px, pw;
    logic [YW-1:0] py, ph;
    logic [XW-1:0] qx0, qx1;
    logic [YW-1:0] qy0, qy1;
    logic          qv0, qv1, busy0, busy1, done0, done1, safe0, safe1;
    logic          is_safe0;
    logic          is_safe1 = 1'b1;
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
    logic [12:0]   cnt0, cnt1;
`endif

    int ubx = -1;
    int uby = -1;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct { int qx; int qy; } q_t;
    typedef struct { int cyc; int safe; int cnt; } d_t;
    q_t q0[$];
    q_t q1[$];
    d_t d0[$];
    d_t d1[$];
    q_t m0_q, m1_q;
    d_t m0_d, m1_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Map responders: one block (ubx,uby) may be marked unsafe.
    assign is_safe0 = !((int'(qx0) / 10 == ubx) && (int'(qy0) / 10 == uby));
    always @(posedge clk) is_safe1 <= !((int'(qx1) / 10 == ubx) && (int'(qy1) / 10 == uby));

    safe_zone_checker #(.QUERY_LAT(0)) dut (
        .clk(clk), .rst(rst), .i_start(start0),
        .i_px(px), .i_py(py), .i_pw(pw), .i_ph(ph),
        .i_map_rdy(map_rdy), .o_qx(qx0), .o_qy(qy0), .o_qvalid(qv0),
        .i_is_safe(is_safe0), .o_busy(busy0), .o_done(done0), .o_safe(safe0)
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
        , .o_unsafe_cnt(cnt0)
`endif
    );

    safe_zone_checker #(.QUERY_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .i_start(start1),
        .i_px(px), .i_py(py), .i_pw(pw), .i_ph(ph),
        .i_map_rdy(map_rdy), .o_qx(qx1), .o_qy(qy1), .o_qvalid(qv1),
        .i_is_safe(is_safe1), .o_busy(busy1), .o_done(done1), .o_safe(safe1)
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
        , .o_unsafe_cnt(cnt1)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference scan: row-major over clipped blocks; without the count feature
    // the scan stops at the first unsafe block.
    task automatic push_scan(input int x, input int y, input int w, input int h, input int t,
                             input int lat, input int extra, input int max_q, input bit with_done);
        int bx0, bx1, by0, by1, xe, ye;
        int n;
        int bad;
        bit stop;
        q_t e;
        d_t d;
        n = 0; bad = 0; stop = 1'b0;
        if (w != 0 && h != 0 && x < 800 && y < 600) begin
            xe  = (x + w - 1 > 799) ? 799 : x + w - 1;
            ye  = (y + h - 1 > 599) ? 599 : y + h - 1;
            bx0 = x / 10; bx1 = xe / 10;
            by0 = y / 10; by1 = ye / 10;
            for (int yy = by0; yy <= by1 && !stop; yy++) begin
                for (int xx = bx0; xx <= bx1 && !stop; xx++) begin
                    if (n < max_q) begin
                        e.qx = xx * 10;
                        e.qy = yy * 10;
                        if (lat != 0) q1.push_back(e); else q0.push_back(e);
                    end
                    n++;
                    if (xx == ubx && yy == uby) begin
                        bad++;
`ifndef SAFE_ZONE_UNSAFE_COUNT_EN
                        stop = 1'b1;
`endif
                    end
                end
            end
        end
        if (with_done) begin
            d.cyc  = t + 2 + extra + n * (1 + lat);
            d.safe = (bad == 0) ? 1 : 0;
            d.cnt  = bad;
            if (lat != 0) d1.push_back(d); else d0.push_back(d);
        end
    endtask

    // Monitor for the combinational-map instance.
    always @(negedge clk) begin
        if (qv0) begin
            if (q0.size() == 0) chk("dut0_unexpected_query", int'(qv0), 0);
            else begin
                m0_q = q0.pop_front();
                chk("dut0_qx", int'(qx0), m0_q.qx);
                chk("dut0_qy", int'(qy0), m0_q.qy);
            end
        end
        if (done0) begin
            if (d0.size() == 0) chk("dut0_unexpected_done", int'(done0), 0);
            else begin
                m0_d = d0.pop_front();
                $display("dut0 done cyc=%0d safe=%0d", cyc, safe0);
                chk("dut0_done_cycle", cyc, m0_d.cyc);
                chk("dut0_safe", int'(safe0), m0_d.safe);
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
                chk("dut0_unsafe_cnt", int'(cnt0), m0_d.cnt);
`endif
            end
        end
    end

    // Monitor for the registered-map instance.
    always @(negedge clk) begin
        if (qv1) begin
            if (q1.size() == 0) chk("dut1_unexpected_query", int'(qv1), 0);
            else begin
                m1_q = q1.pop_front();
                chk("dut1_qx", int'(qx1), m1_q.qx);
                chk("dut1_qy", int'(qy1), m1_q.qy);
            end
        end
        if (done1) begin
            if (d1.size() == 0) chk("dut1_unexpected_done", int'(done1), 0);
            else begin
                m1_d = d1.pop_front();
                $display("dut1 done cyc=%0d safe=%0d", cyc, safe1);
                chk("dut1_done_cycle", cyc, m1_d.cyc);
                chk("dut1_safe", int'(safe1), m1_d.safe);
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
                chk("dut1_unsafe_cnt", int'(cnt1), m1_d.cnt);
`endif
            end
        end
    end

    task automatic kick(input int x, input int y, input int w, input int h, input bit lat1, output int t);
        @(posedge clk); #1;
        px = XW'(x); py = YW'(y); pw = XW'(w); ph = YW'(h);
        if (lat1) start1 = 1'b1; else start0 = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while ((q0.size() != 0 || q1.size() != 0 || d0.size() != 0 || d1.size() != 0 || busy0 || busy1) && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        if (i >= 100) begin
            chk({tag, "_timeout_pending"}, q0.size() + q1.size() + d0.size() + d1.size(), 0);
            q0.delete(); q1.delete(); d0.delete(); d1.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;
        rst = 1'b1; map_rdy = 1'b1; start0 = 1'b0; start1 = 1'b0;
        px = '0; py = '0; pw = '0; ph = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   int'(busy0), 0);
        chk("rst_done",   int'(done0), 0);
        chk("rst_safe",   int'(safe0), 0);
        chk("rst_qvalid", int'(qv0),   0);
        chk("rst_qx",     int'(qx0),   0);
        chk("rst_qy",     int'(qy0),   0);
        chk("rst_busy_l1", int'(busy1), 0);
`ifdef SAFE_ZONE_UNSAFE_COUNT_EN
        chk("rst_cnt", int'(cnt0), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // All-safe map, 2x3 blocks.
        kick(15, 25, 20, 10, 1'b0, t);
        push_scan(15, 25, 20, 10, t, 0, 0, 99, 1'b1);
        wait_idle("t1");

        // Block (2,3) unsafe.
        ubx = 2; uby = 3;
        kick(15, 25, 20, 10, 1'b0, t);
        push_scan(15, 25, 20, 10, t, 0, 0, 99, 1'b1);
        wait_idle("t2");
        ubx = -1; uby = -1;

        // Bottom-right corner box clipped to one block.
        kick(795, 595, 20, 20, 1'b0, t);
        push_scan(795, 595, 20, 20, t, 0, 0, 99, 1'b1);
        wait_idle("t3");

        // Zero width: no queries, immediate safe result.
        kick(15, 25, 0, 10, 1'b0, t);
        push_scan(15, 25, 0, 10, t, 0, 0, 99, 1'b1);
        wait_idle("t4");

        // Map ready drops during the 3rd query for 4 cycles: restart from the first block.
        kick(15, 25, 20, 10, 1'b0, t);
        push_scan(15, 25, 20, 10, t, 0, 0, 3, 1'b0);
        push_scan(15, 25, 20, 10, t, 0, 7, 99, 1'b1);
        wait_cyc(t + 4);
        map_rdy = 1'b0;
        wait_cyc(t + 8);
        map_rdy = 1'b1;
        wait_idle("t5");

        // Start pulse while busy, with a different box, must be ignored.
        kick(15, 25, 20, 10, 1'b0, t);
        push_scan(15, 25, 20, 10, t, 0, 0, 99, 1'b1);
        wait_cyc(t + 3);
        px = '0; py = '0; pw = XW'(5); ph = YW'(5);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_idle("t6_busy_start");

        // Reset mid-scan: outputs clear next cycle and no done pulse follows.
        kick(15, 25, 20, 10, 1'b0, t);
        push_scan(15, 25, 20, 10, t, 0, 0, 3, 1'b0);
        wait_cyc(t + 4);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy",   int'(busy0), 0);
        chk("midrst_done",   int'(done0), 0);
        chk("midrst_safe",   int'(safe0), 0);
        chk("midrst_qvalid", int'(qv0),   0);
        chk("midrst_qx",     int'(qx0),   0);
        chk("midrst_qy",     int'(qy0),   0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Registered map responder, all safe then one unsafe block.
        kick(15, 25, 20, 10, 1'b1, t);
        push_scan(15, 25, 20, 10, t, 1, 0, 99, 1'b1);
        wait_idle("t7_lat1");
        ubx = 2; uby = 3;
        kick(15, 25, 20, 10, 1'b1, t);
        push_scan(15, 25, 20, 10, t, 1, 0, 99, 1'b1);
        wait_idle("t7_lat1_unsafe");
        ubx = -1; uby = -1;

        repeat (3) @(posedge clk);
        #1;
        chk("leftover_expectations", q0.size() + q1.size() + d0.size() + d1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
